// File: rtl/calc1_pkg.sv
// Shared definitions for calc1: fixed widths, command/response codes,
// per-port FSM states and the combinational ALU used by each port.
package calc1_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned RESP_W  = 2;
    localparam int unsigned RESET_W = 7;

    localparam logic [0:CMD_W-1] CMD_NOP = 4'd0;
    localparam logic [0:CMD_W-1] CMD_ADD = 4'd1;
    localparam logic [0:CMD_W-1] CMD_SUB = 4'd2;
    localparam logic [0:CMD_W-1] CMD_LSH = 4'd5;
    localparam logic [0:CMD_W-1] CMD_RSH = 4'd6;

    localparam logic [0:RESP_W-1] RSP_NONE = 2'd0;
    localparam logic [0:RESP_W-1] RSP_SUCC = 2'd1;
    localparam logic [0:RESP_W-1] RSP_INOF = 2'd2;
    // Reserved code; the reference model never produces it.
    localparam logic [0:RESP_W-1] RSP_IERR = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOp2  = 2'd1,
        StResp = 2'd2
    } state_e;

    typedef struct packed {
        logic [0:RESP_W-1] resp;
        logic [0:DATA_W-1] data;
    } result_t;

    // Unsigned 32-bit ALU. Any non-success response carries zero data.
    function automatic result_t calc_alu(input logic [0:CMD_W-1]  cmd,
                                         input logic [0:DATA_W-1] op1,
                                         input logic [0:DATA_W-1] op2);
        result_t       res;
        logic [DATA_W:0] sum;
        res.resp = RSP_INOF;
        res.data = '0;
        sum      = {1'b0, op1} + {1'b0, op2};
        case (cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    res.resp = RSP_SUCC;
                    res.data = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    res.resp = RSP_SUCC;
                    res.data = op1 - op2;
                end
            end
            // Only the five least-significant bits of op2 select the shift.
            CMD_LSH: begin
                res.resp = RSP_SUCC;
                res.data = op1 << op2[DATA_W-5:DATA_W-1];
            end
            CMD_RSH: begin
                res.resp = RSP_SUCC;
                res.data = op1 >> op2[DATA_W-5:DATA_W-1];
            end
            default: ;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/calc1_port_unit.sv
// One calc1 port: command/operand FSM (IDLE -> OP2 -> RESP) plus ALU.
// The response is registered for a single cycle; a new command may be
// accepted on the same edge that registers the response.
module calc1_port_unit
    import calc1_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [0:CMD_W-1]  i_cmd,
    input  logic [0:DATA_W-1] i_data,
    output logic [0:DATA_W-1] o_data,
    output logic [0:RESP_W-1] o_resp
);

    state_e            r_state;
    state_e            w_state_next;
    logic              w_accept;
    logic [0:CMD_W-1]  r_cmd;
    logic [0:DATA_W-1] r_op1;
    logic [0:DATA_W-1] r_op2;
    logic [0:DATA_W-1] r_data;
    logic [0:RESP_W-1] r_resp;
    result_t           w_result;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and command acceptance; an X command compares as not-true and is a NOP
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            StIdle, StResp: begin
                if (i_cmd != CMD_NOP) begin
                    w_accept     = 1'b1;
                    w_state_next = StOp2;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StOp2:   w_state_next = StResp;
            default: w_state_next = StIdle;
        endcase
    end

    assign w_result = calc_alu(r_cmd, r_op1, r_op2);

    // Operand capture and one-cycle registered response
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmd  <= CMD_NOP;
            r_op1  <= '0;
            r_op2  <= '0;
            r_resp <= RSP_NONE;
            r_data <= '0;
        end else begin
            r_resp <= RSP_NONE;
            r_data <= '0;
            if (w_accept) begin
                r_cmd <= i_cmd;
                r_op1 <= i_data;
            end
            if (r_state == StOp2) begin
                r_op2 <= i_data;
            end
            if (r_state == StResp) begin
                r_resp <= w_result.resp;
                r_data <= w_result.data;
            end
        end
    end

    assign o_resp = r_resp;
    assign o_data = r_data;

endmodule

// File: rtl/calc1_reference_model.sv
// calc1 golden model: four independent calculator ports sharing one clock
// and an OR-reduced asynchronous reset.
module calc1_reference_model
    import calc1_pkg::*;
(
    input  logic               c_clk,
    input  logic [1:RESET_W]   reset,
    input  logic [0:CMD_W-1]   req1_cmd_in,
    input  logic [0:DATA_W-1]  req1_data_in,
    input  logic [0:CMD_W-1]   req2_cmd_in,
    input  logic [0:DATA_W-1]  req2_data_in,
    input  logic [0:CMD_W-1]   req3_cmd_in,
    input  logic [0:DATA_W-1]  req3_data_in,
    input  logic [0:CMD_W-1]   req4_cmd_in,
    input  logic [0:DATA_W-1]  req4_data_in,
    output logic [0:DATA_W-1]  out_data1,
    output logic [0:RESP_W-1]  out_resp1,
    output logic [0:DATA_W-1]  out_data2,
    output logic [0:RESP_W-1]  out_resp2,
    output logic [0:DATA_W-1]  out_data3,
    output logic [0:RESP_W-1]  out_resp3,
    output logic [0:DATA_W-1]  out_data4,
    output logic [0:RESP_W-1]  out_resp4
);

    logic w_rst;

    // Any asserted reset bit resets every port
    assign w_rst = |reset;

    calc1_port_unit u_port1 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req1_cmd_in),
        .i_data (req1_data_in),
        .o_data (out_data1),
        .o_resp (out_resp1)
    );

    calc1_port_unit u_port2 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req2_cmd_in),
        .i_data (req2_data_in),
        .o_data (out_data2),
        .o_resp (out_resp2)
    );

    calc1_port_unit u_port3 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req3_cmd_in),
        .i_data (req3_data_in),
        .o_data (out_data3),
        .o_resp (out_resp3)
    );

    calc1_port_unit u_port4 (
        .i_clk  (c_clk),
        .i_rst  (w_rst),
        .i_cmd  (req4_cmd_in),
        .i_data (req4_data_in),
        .o_data (out_data4),
        .o_resp (out_resp4)
    );

endmodule

// File: tb/tb_calc1_reference_model.sv
// Bench for calc1_reference_model. Stimulus is planned per port and per clock
// edge; expected responses come from a transaction-level arithmetic model and
// are placed two edges after the command edge. Every port is checked after
// every edge (unplanned edges expect resp 0 / data 0).
module tb_calc1_reference_model;

    localparam int MaxE = 1024;

    logic        c_clk = 1'b0;
    logic [1:7]  reset;
    logic [0:3]  cmd  [4];
    logic [0:31] din  [4];
    logic [0:31] dout [4];
    logic [0:1]  resp [4];

    logic [0:3]  p_cmd  [4][MaxE];
    logic [0:31] p_dat  [4][MaxE];
    bit          p_set  [4][MaxE];
    logic [0:1]  x_resp [4][MaxE];
    logic [0:31] x_dat  [4][MaxE];

    int cur         = 0;
    int vectors     = 0;
    int miscompares = 0;

    always #5 c_clk = ~c_clk;

    calc1_reference_model dut (
        .c_clk        (c_clk),
        .reset        (reset),
        .req1_cmd_in  (cmd[0]),
        .req1_data_in (din[0]),
        .req2_cmd_in  (cmd[1]),
        .req2_data_in (din[1]),
        .req3_cmd_in  (cmd[2]),
        .req3_data_in (din[2]),
        .req4_cmd_in  (cmd[3]),
        .req4_data_in (din[3]),
        .out_data1    (dout[0]),
        .out_resp1    (resp[0]),
        .out_data2    (dout[1]),
        .out_resp2    (resp[1]),
        .out_data3    (dout[2]),
        .out_resp3    (resp[2]),
        .out_data4    (dout[3]),
        .out_resp4    (resp[3])
    );

    // Transaction-level arithmetic: 64-bit math detects carry/borrow directly.
    function automatic void model(input logic [0:3] c, input logic [0:31] a,
                                  input logic [0:31] b, output logic [0:1] r,
                                  output logic [0:31] d);
        longint unsigned la, lb;
        int k;
        la = 64'(a);
        lb = 64'(b);
        k  = int'(lb % 64'd32);
        r  = 2'd2;
        d  = '0;
        case (c)
            4'd1: if (la + lb <= 64'hFFFF_FFFF) begin r = 2'd1; d = 32'(la + lb); end
            4'd2: if (lb <= la) begin r = 2'd1; d = 32'(la - lb); end
            4'd5: begin r = 2'd1; d = 32'(la << k); end
            4'd6: begin r = 2'd1; d = 32'(la >> k); end
            default: ;
        endcase
    endfunction

    function automatic void clear_from(input int e0);
        for (int p = 0; p < 4; p++) begin
            for (int e = e0; e < MaxE; e++) begin
                p_set[p][e]  = 1'b0;
                p_cmd[p][e]  = 4'd0;
                p_dat[p][e]  = '0;
                x_resp[p][e] = 2'd0;
                x_dat[p][e]  = '0;
            end
        end
    endfunction

    // Command+op1 at edge e, op2 at e+1 (with junk on cmd), response after e+2.
    function automatic void sched(input int p, input int e, input logic [0:3] c,
                                  input logic [0:31] a, input logic [0:31] b,
                                  input logic [0:1] r, input logic [0:31] d);
        p_set[p][e]    = 1'b1;
        p_cmd[p][e]    = c;
        p_dat[p][e]    = a;
        p_set[p][e+1]  = 1'b1;
        p_cmd[p][e+1]  = 4'($urandom);
        p_dat[p][e+1]  = b;
        x_resp[p][e+2] = r;
        x_dat[p][e+2]  = d;
    endfunction

    function automatic void sched_model(input int p, input int e, input logic [0:3] c,
                                        input logic [0:31] a, input logic [0:31] b);
        logic [0:1]  r;
        logic [0:31] d;
        model(c, a, b, r, d);
        sched(p, e, c, a, b, r, d);
    endfunction

    function automatic logic [0:3] rand_cmd();
        logic [0:3] c;
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 2)       c = 4'd1;
        else if (sel < 4)  c = 4'd2;
        else if (sel == 4) c = 4'd5;
        else if (sel == 5) c = 4'd6;
        else begin
            do c = 4'($urandom_range(3, 15)); while (c == 4'd5 || c == 4'd6);
        end
        return c;
    endfunction

    function automatic logic [0:31] rand_val();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
    endfunction

    // Drive the plan for edge cur, then check all ports half a cycle after it.
    task automatic step();
        for (int p = 0; p < 4; p++) begin
            if (p_set[p][cur]) begin
                cmd[p] = p_cmd[p][cur];
                din[p] = p_dat[p][cur];
            end else begin
                cmd[p] = 4'd0;
                din[p] = $urandom;
            end
        end
        @(posedge c_clk);
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            vectors++;
            if (resp[p] !== x_resp[p][cur]) begin
                miscompares++;
                $display("FAIL resp port%0d edge %0d: got %0d want %0d",
                         p + 1, cur, resp[p], x_resp[p][cur]);
            end
            vectors++;
            if (dout[p] !== x_dat[p][cur]) begin
                miscompares++;
                $display("FAIL data port%0d edge %0d: got %h want %h",
                         p + 1, cur, dout[p], x_dat[p][cur]);
            end
        end
        cur++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_zero_now(input string tag);
        for (int p = 0; p < 4; p++) begin
            vectors++;
            if (resp[p] !== 2'd0 || dout[p] !== 32'd0) begin
                miscompares++;
                $display("FAIL %s port%0d: got resp %0d data %h want 0/0",
                         tag, p + 1, resp[p], dout[p]);
            end
        end
    endtask

    // Reset held with nonzero commands on every port: nothing may be accepted.
    task automatic test_reset();
        clear_from(0);
        reset = 7'b0000001;
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd1;
            din[p] = $urandom;
        end
        #1;
        check_zero_now("reset_initial");
        for (int e = 0; e < 3; e++) begin
            for (int p = 0; p < 4; p++) begin
                p_set[p][e] = 1'b1;
                p_cmd[p][e] = 4'd1;
                p_dat[p][e] = $urandom;
            end
        end
        steps(3);
        reset = 7'b0000000;
        steps(2);
    endtask

    task automatic test_add_latency();
        sched(0, cur, 4'd1, 32'd255, 32'd255, 2'd1, 32'd510);
        steps(5);
    endtask

    task automatic test_boundaries();
        sched(0, cur, 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 32'd0);
        sched(1, cur, 4'd2, 32'd5, 32'd7, 2'd2, 32'd0);
        sched(2, cur, 4'd2, 32'd7, 32'd5, 2'd1, 32'd2);
        sched(3, cur, 4'd5, 32'd1, 32'h0000_0025, 2'd1, 32'h20);
        steps(4);
        sched(0, cur, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1);
        sched(1, cur, 4'd3, 32'd9, $urandom, 2'd2, 32'd0);
        sched(2, cur, 4'd1, 32'hFFFF_FFFF, 32'd0, 2'd1, 32'hFFFF_FFFF);
        sched(3, cur, 4'd2, 32'd7, 32'd7, 2'd1, 32'd0);
        steps(4);
    endtask

    task automatic test_parallel();
        for (int p = 0; p < 4; p++) begin
            sched(p, cur, 4'd1, 32'(p + 1), 32'(p + 1), 2'd1, 32'(2 * (p + 1)));
        end
        steps(4);
    endtask

    task automatic test_back_to_back();
        int e0;
        e0 = cur;
        for (int p = 0; p < 4; p++) begin
            for (int t = 0; t < 4; t++) begin
                sched_model(p, e0 + 2 * t, rand_cmd(), rand_val(), rand_val());
            end
        end
        steps(11);
    endtask

    // Reset lands between op2 and response on port1 while port2's response is visible.
    task automatic test_reset_midflight();
        int e0;
        e0 = cur;
        sched(1, e0, 4'd1, 32'd20, 32'd22, 2'd1, 32'd42);
        sched(0, e0 + 1, 4'd1, 32'd3, 32'd4, 2'd1, 32'd7);
        x_resp[0][e0 + 3] = 2'd0;
        x_dat[0][e0 + 3]  = '0;
        steps(3);
        reset = 7'b1000000;
        #1;
        check_zero_now("reset_async");
        clear_from(cur);
        for (int e = cur; e < cur + 2; e++) begin
            for (int p = 0; p < 4; p++) begin
                p_set[p][e] = 1'b1;
                p_cmd[p][e] = 4'd2;
                p_dat[p][e] = $urandom;
            end
        end
        steps(2);
        reset = 7'b0000000;
        sched(0, cur, 4'd1, 32'd100, 32'd1, 2'd1, 32'd101);
        sched(0, cur + 2, 4'd2, 32'd100, 32'd1, 2'd1, 32'd99);
        sched(0, cur + 4, 4'd5, 32'd3, 32'd2, 2'd1, 32'd12);
        steps(8);
    endtask

    task automatic test_random(input int n);
        int e0;
        int nf [4];
        e0 = cur;
        for (int p = 0; p < 4; p++) nf[p] = e0;
        for (int e = e0; e < e0 + n; e++) begin
            for (int p = 0; p < 4; p++) begin
                if (e >= nf[p] && $urandom_range(0, 3) != 0) begin
                    sched_model(p, e, rand_cmd(), rand_val(), rand_val());
                    nf[p] = e + 2;
                end
            end
        end
        steps(n + 3);
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_boundaries();
        test_parallel();
        test_back_to_back();
        test_reset_midflight();
        test_random(300);
        steps(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
